// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, SPI mode constants and default widths
package spi_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETUP    = 2'd1,
      TRANSFER = 2'd2,
      HOLD     = 2'd3
   } state_e;
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DIV_W  = 8;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter producing half-period ticks and leading/trailing edge strobes
// Ports: CLK_I/RST_I clock and sync reset; en_i runs the counter (cleared when low);
//        div_i captured divider (half-period = div_i+1 cycles); half_tick_o end of each
//        half-period; lead_o/trail_o qualify that tick as a leading or trailing SCLK edge.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             CLK_I,
   input  logic             RST_I,
   input  logic             en_i,
   input  logic [DIV_W-1:0] div_i,
   output logic             half_tick_o,
   output logic             lead_o,
   output logic             trail_o
);
   logic [DIV_W-1:0] cnt_q;
   logic             phase_q;
   assign half_tick_o = en_i && (cnt_q == div_i);
   // phase flips every half-period; the setup half-period leaves it set so that
   // the first transfer half-period ends on a leading edge
   assign lead_o  = half_tick_o && phase_q;
   assign trail_o = half_tick_o && !phase_q;
   always_ff @(posedge CLK_I) begin
      if (RST_I || !en_i) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (half_tick_o) begin
         cnt_q   <= '0;
         phase_q <= !phase_q;
      end else begin
         cnt_q   <= cnt_q + 1'b1;
      end
   end
endmodule

// File: rtl/spi_master_core.sv
// spi_master_core: SPI shift engine serialising one byte MSB-first with CPOL/CPHA and clock divider
// Ports: CLK_I/RST_I clock and sync reset; start_i transfer request; tx_data_i byte to send;
//        clk_div_i half-period minus one; cpol_i/cpha_i SPI mode; busy_o transfer active;
//        done_o completion pulse; rx_data_o last received byte; sclk_o/mosi_o/miso_i/ss_n_o SPI bus.
module spi_master_core
   import spi_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DIV_W  = DEF_DIV_W
) (
   input  logic              CLK_I,
   input  logic              RST_I,
   input  logic              start_i,
   input  logic [DATA_W-1:0] tx_data_i,
   input  logic [DIV_W-1:0]  clk_div_i,
   input  logic              cpol_i,
   input  logic              cpha_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              sclk_o,
   output logic              mosi_o,
   input  logic              miso_i,
   output logic              ss_n_o
);
   localparam int EW = $clog2(2 * DATA_W) + 1;
   state_e            state_q, state_d;
   logic [EW-1:0]     edge_q, edge_d;
   logic [DIV_W-1:0]  div_q;
   logic              cpha_q;
   logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
   logic              sclk_q, mosi_q, done_q;
   logic              tick, lead, trail, xfer, last_edge, sample, shift, finish;
   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .CLK_I       (CLK_I),
      .RST_I       (RST_I),
      .en_i        (state_q != IDLE),
      .div_i       (div_q),
      .half_tick_o (tick),
      .lead_o      (lead),
      .trail_o     (trail)
   );
   assign xfer      = state_q == TRANSFER;
   assign last_edge = edge_q == EW'(2 * DATA_W - 1);
   assign finish    = (state_q == HOLD) && tick;
   assign sample    = xfer && (cpha_q ? trail : lead);
   // cpha=0 presents the MSB during setup, so its final trailing edge has nothing left to shift
   assign shift     = xfer && (cpha_q ? lead : (trail && !last_edge));
   always_comb begin
      state_d = (state_q == IDLE && start_i)            ? SETUP    :
                (state_q == SETUP && tick)              ? TRANSFER :
                (xfer && tick && last_edge)             ? HOLD     :
                finish                                  ? IDLE     : state_q;
      edge_d  = (xfer && tick) ? (last_edge ? '0 : edge_q + 1'b1) : edge_q;
   end
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q   <= IDLE;
         edge_q    <= '0;
         div_q     <= '0;
         cpha_q    <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         mosi_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         edge_q  <= edge_d;
         done_q  <= finish;
         if (finish) rx_data_q <= rx_q;
         if (state_q == IDLE) begin
            sclk_q <= cpol_i;
            if (start_i) begin
               div_q  <= clk_div_i;
               cpha_q <= cpha_i;
               tx_q   <= tx_data_i;
               if (!cpha_i) mosi_q <= tx_data_i[DATA_W-1];
            end
         end else if (xfer && tick) begin
            sclk_q <= !sclk_q;
         end
         if (sample) rx_q <= {rx_q[DATA_W-2:0], miso_i};
         if (shift) begin
            mosi_q <= cpha_q ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
            tx_q   <= tx_q << 1;
         end
      end
   end
   assign busy_o    = state_q != IDLE;
   assign ss_n_o    = state_q == IDLE;
   assign done_o    = done_q;
   assign rx_data_o = rx_data_q;
   assign sclk_o    = sclk_q;
   assign mosi_o    = mosi_q;
endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- SPI shift engine sitting directly downstream of the Wishbone slave register block (CLK_I/RST_I/ADR_I/DAT_I/STB_I/CYC_I/WE_I/ACK_O).
- The register block hands it one byte plus mode/divider settings and a start strobe.
- The engine serialises the byte on MOSI, captures MISO, drives SCLK and SS_n, and returns the received byte with a done pulse the register block exposes on DAT_O.

Parameters:
- DATA_W, 8, bits per transfer.
- DIV_W, 8, width of clock-divider input.

Ports:
- CLK_I  input  1  system clock; all logic on rising edge.
- RST_I  input  1  synchronous, active-high reset.
- start_i  input  1  transfer request strobe from the register block.
- tx_data_i  input  DATA_W  byte to transmit, MSB first.
- clk_div_i  input  DIV_W  half-period = clk_div_i+1 CLK_I cycles.
- cpol_i  input  1  SCLK idle level.
- cpha_i  input  1  0 = sample leading edge; 1 = sample trailing edge.
- busy_o  output  1  transfer in progress.
- done_o  output  1  one-cycle completion pulse.
- rx_data_o  output  DATA_W  last received byte.
- sclk_o  output  1  SPI clock.
- mosi_o  output  1  SPI data out.
- miso_i  input  1  SPI data in (already synchronised externally).
- ss_n_o  output  1  slave select, active low.

Behaviour:
- Interface (already decided): one clock, CLK_I; reset RST_I is synchronous and active-high.
- Reset values: busy_o=0, done_o=0, rx_data_o=0, sclk_o=0, mosi_o=0, ss_n_o=1, FSM=IDLE, counters=0.
- RST_I asserted mid-transfer: all outputs return to reset values at the next edge; no done_o pulse.
- Let H = clk_div_i+1. The following are sampled on the accepting edge and held for the whole transfer; changes mid-transfer have no effect:
  - clk_div_i, cpol_i, cpha_i
  - tx_data_i, loaded into the shift register.
- FSM states:
  - IDLE: sclk_o follows registered cpol_i. start_i=1 → SETUP at the next edge, with ss_n_o=0 and busy_o=1 from that edge. start_i is ignored in every other state.
  - SETUP: H cycles, sclk_o=CPOL.
    - cpha=0: mosi_o = MSB of tx_data from SETUP entry.
    - cpha=1: mosi_o is unchanged until the first edge.
  - TRANSFER: 2*DATA_W half-periods of H cycles each; sclk_o toggles at each half-period boundary (exactly DATA_W leading and DATA_W trailing edges).
    - cpha=0: sample miso_i on leading edges; shift mosi_o on trailing edges, except the final one.
    - cpha=1: shift mosi_o on leading edges; sample miso_i on trailing edges.
  - HOLD: H cycles, sclk_o=CPOL, ss_n_o still 0. Then → IDLE.
- IDLE entry after HOLD, same edge: ss_n_o=1, busy_o=0, done_o=1 for exactly one cycle, rx_data_o updated.
- rx_data_o is held until the next completion.
- start_i asserted in the done_o cycle is accepted: back-to-back transfer with SS_n high for exactly that one cycle.
- Latency, start sampled at edge T0: ss_n_o low T1..T(2H+2*DATA_W*H); done_o at T(2H+2*DATA_W*H+1).
  - For H=1, DATA_W=8: ss_n_o low T1..T18; done_o at T19.
- Counters:
  - half-period counter, DIV_W bits, counts 0..H-1;
  - edge counter, clog2(2*DATA_W)+1 bits;
  - no wrap beyond terminal counts.

Decomposition:
- Package spi_pkg:
  - FSM state enum (IDLE, SETUP, TRANSFER, HOLD);
  - SPI mode constants MODE0..MODE3 as {cpol,cpha};
  - default DATA_W/DIV_W.
- Sub-module spi_clk_gen: half-period counter. Inputs: enable, captured divider. Outputs: half_tick strobe and leading/trailing edge strobes. spi_master_core instantiates it once.

Test Plan:
- Mode0, div=0, tx=0xA5, miso looped to mosi → rx_data_o=0xA5; done_o at T19; exactly 8 rising SCLK edges; ss_n_o low T1..T18.
- Mode3, div=3, tx=0x5A, slave model returning 0x3C on falling edges → rx_data_o=0x3C; SCLK idles high; half-period 4 cycles; done_o at T(8+64+1)=T73.
- start_i pulsed mid-TRANSFER with tx=0xFF → ignored; current byte completes unchanged; a single done_o pulse.
- start_i held high through done_o, tx 0x11 then 0x22 → two transfers; ss_n_o high for exactly one cycle between them; rx_data_o shows each byte in turn.
- RST_I asserted at the 5th SCLK edge → next cycle ss_n_o=1, sclk_o=0, busy_o=0; no done_o; the next transfer works normally.
- clk_div_i and cpol_i changed mid-transfer → SCLK period and polarity unchanged until IDLE; the new values apply to the next transfer.
